// File: rtl/led_nibble_capture_if.sv
// Pin-side bundle for led_nibble_capture: raw nibble/strobe lines in, captured word out.
interface led_nibble_capture_if;
    logic [3:0]  nib_in;
    logic        pos_in;
    logic [31:0] value;
    logic        valid;
    logic        frame_err;
    logic        busy;

    // Handshake: valid and frame_err are one-cycle pulses with no back-pressure and are
    // never high together; value is stable from its valid cycle until the next valid;
    // busy is a level that is high while a frame is being captured.
    modport master (output nib_in, pos_in, input value, valid, frame_err, busy);
    modport slave  (input nib_in, pos_in, output value, valid, frame_err, busy);
endinterface

// File: rtl/led_nibble_capture.sv
// Receive side of the LED nibble-cycling link: rebuilds a 32-bit word from eight
// nibble slots (slot 0 marked by the position strobe), pulses valid on success and
// frame_err on a framing violation or a mid-frame re-sync.
// Optional macro LED_NIBBLE_CAPTURE_MAJORITY_EN: 3-point majority sampling, which
// moves every sample (and valid) one cycle later.
module led_nibble_capture #(
    parameter int NIBBLE_CYCLES = 6000000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    led_nibble_capture_if.slave  bus,
    output logic [2:0]           state_dbg
);

    localparam int CW = $clog2(NIBBLE_CYCLES);
`ifdef LED_NIBBLE_CAPTURE_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // ALIGN starts at cyc=0 one cycle after the strobe edge; sample lands at t0+N/2(+1).
    localparam logic [CW-1:0] ALIGN_LAST = CW'(NIBBLE_CYCLES / 2 - 2 + MAJ);
    // WAIT spans the N-1 cycles between two consecutive samples.
    localparam logic [CW-1:0] WAIT_LAST  = CW'(NIBBLE_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_SAMPLE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    logic [3:0]             nib_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] pos_sync;
    logic [3:0]             nib_s;
    logic                   pos_s;
    logic                   pos_prev;
    logic                   pos_rise;
    logic [3:0]             nib_smp;
    logic                   pos_smp;

    state_t        state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [2:0]    slot, slot_n;
    logic [31:0]   shreg, shreg_n;
    logic [31:0]   value_q, value_n;
    logic          resync, resync_n;

    // Synchronizer chains for the asynchronous pins; no reset so they only ever carry pin history.
    always_ff @(posedge clk) begin
        nib_sync[0] <= bus.nib_in;
        pos_sync[0] <= bus.pos_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            nib_sync[i] <= nib_sync[i-1];
            pos_sync[i] <= pos_sync[i-1];
        end
    end

    assign nib_s = nib_sync[SYNC_STAGES-1];
    assign pos_s = pos_sync[SYNC_STAGES-1];

    // Previous synchronized strobe, for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_prev <= 1'b0;
        end else begin
            pos_prev <= pos_s;
        end
    end

    assign pos_rise = pos_s & ~pos_prev;

`ifdef LED_NIBBLE_CAPTURE_MAJORITY_EN
    logic [3:0] nib_d1;
    logic [3:0] nib_d2;
    logic       pos_d2;

    // Two-deep history so the SAMPLE cycle sees sample point -1, the point itself, and +1.
    always_ff @(posedge clk) begin
        if (rst) begin
            nib_d1 <= 4'd0;
            nib_d2 <= 4'd0;
            pos_d2 <= 1'b0;
        end else begin
            nib_d1 <= nib_s;
            nib_d2 <= nib_d1;
            pos_d2 <= pos_prev;
        end
    end

    assign nib_smp = (nib_d2 & nib_d1) | (nib_d2 & nib_s) | (nib_d1 & nib_s);
    assign pos_smp = (pos_d2 & pos_prev) | (pos_d2 & pos_s) | (pos_prev & pos_s);
`else
    assign nib_smp = nib_s;
    assign pos_smp = pos_s;
`endif

    // State, counters, shift register and output word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cyc     <= '0;
            slot    <= 3'd0;
            shreg   <= 32'd0;
            value_q <= 32'd0;
            resync  <= 1'b0;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            slot    <= slot_n;
            shreg   <= shreg_n;
            value_q <= value_n;
            resync  <= resync_n;
        end
    end

    // Frame sequencing: align to mid-slot, sample eight slots, then report success or error.
    always_comb begin
        state_n  = state;
        cyc_n    = cyc;
        slot_n   = slot;
        shreg_n  = shreg;
        value_n  = value_q;
        resync_n = resync;
        unique case (state)
            S_IDLE: begin
                if (pos_rise) begin
                    state_n = S_ALIGN;
                    cyc_n   = '0;
                    slot_n  = 3'd0;
                end
            end
            S_ALIGN: begin
                if (cyc == ALIGN_LAST) begin
                    state_n = S_SAMPLE;
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            S_SAMPLE: begin
                shreg_n = {shreg[27:0], nib_smp};
                if (pos_smp != (slot == 3'd0)) begin
                    state_n  = S_ERR;
                    resync_n = 1'b0;
                end else if (slot == 3'd7) begin
                    state_n = S_DONE;
                    value_n = {shreg[27:0], nib_smp};
                end else begin
                    state_n = S_WAIT;
                    slot_n  = slot + 3'd1;
                    cyc_n   = '0;
                end
            end
            S_WAIT: begin
                // A fresh strobe edge mid-frame means the sender restarted: abort and follow it.
                if (pos_rise) begin
                    state_n  = S_ERR;
                    resync_n = 1'b1;
                end else if (cyc == WAIT_LAST) begin
                    state_n = S_SAMPLE;
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_ERR: begin
                resync_n = 1'b0;
                if (resync) begin
                    // The ERR cycle already counts as the first aligned cycle after the edge.
                    state_n = S_ALIGN;
                    cyc_n   = CW'(1);
                    slot_n  = 3'd0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.value     = value_q;
    assign bus.valid     = (state == S_DONE);
    assign bus.frame_err = (state == S_ERR);
    assign bus.busy      = (state == S_ALIGN) || (state == S_SAMPLE) || (state == S_WAIT);
    assign state_dbg     = state;

endmodule

// File: tb/tb_led_nibble_capture.sv
// Bench for led_nibble_capture: directed protocol scenarios plus random frames, checked
// every cycle against a frame-timing model of the receiver.
module tb_led_nibble_capture;

    localparam int N    = 8;
    localparam int SS   = 2;
`ifdef LED_NIBBLE_CAPTURE_MAJORITY_EN
    localparam int MAJ  = 1;
`else
    localparam int MAJ  = 0;
`endif
    localparam int H    = N / 2 + MAJ;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;

    led_nibble_capture_if bus();

    led_nibble_capture #(.NIBBLE_CYCLES(N), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / cycle index
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Pin history as driven, indexed by cycle
    logic       hist_pos [MAXC];
    logic [3:0] hist_nib [MAXC];
    logic       hist_rst [MAXC];

    int checks = 0;
    int errors = 0;

    // Scoreboard and model state
    logic [31:0] exp_q[$];
    bit          model_ok = 1'b0;
    bit          m_active = 1'b0;
    int          m_t0 = 0;
    int          m_valid_at = -1;
    int          m_err_at = -1;
    logic        m_prev = 1'b0;
    logic [31:0] m_word = 32'd0;
    logic [31:0] m_value = 32'd0;

    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = -1;
    int prev_valid_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
        end
    endtask

    // Synchronized view of the pins: what the receiver sees SS cycles after driving.
    function automatic logic ps(input int m);
        return (m >= SS) ? hist_pos[m-SS] : 1'b0;
    endfunction

    function automatic logic [3:0] ns(input int m);
        return (m >= SS) ? hist_nib[m-SS] : 4'd0;
    endfunction

    function automatic logic [3:0] maj4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return r;
    endfunction

    // Advance the receiver model by one cycle using the pins seen in cycle n.
    task automatic model_step(input int n);
        logic       p, rise, sp;
        logic [3:0] snb, t3;
        int         d, k;
        if (hist_rst[n]) begin
            m_active   = 1'b0;
            m_prev     = 1'b0;
            m_valid_at = -1;
            m_err_at   = -1;
            m_value    = 32'd0;
            model_ok   = 1'b1;
            exp_q.delete();
            return;
        end
        p    = ps(n);
        rise = p && !m_prev;
        if (m_active) begin
            d = n - m_t0 - H;
            if (d >= 0 && (d % N) == 0) begin
                k = d / N;
                if (MAJ != 0) begin
                    snb = maj4(ns(n-2), ns(n-1), ns(n));
                    t3  = maj4({3'd0, ps(n-2)}, {3'd0, ps(n-1)}, {3'd0, p});
                    sp  = t3[0];
                end else begin
                    snb = ns(n);
                    sp  = p;
                end
                if (sp != (k == 0)) begin
                    m_err_at = n + 1;
                    m_active = 1'b0;
                end else begin
                    m_word = {m_word[27:0], snb};
                    if (k == 7) begin
                        m_valid_at = n + 1;
                        m_value    = m_word;
                        m_active   = 1'b0;
                        exp_q.push_back(m_word);
                    end
                end
            end else if (rise && d > 0) begin
                m_err_at = n + 1;
                m_t0     = n;
                m_word   = 32'd0;
            end
        end else if (rise && n != m_err_at && n != m_valid_at) begin
            m_active = 1'b1;
            m_t0     = n;
            m_word   = 32'd0;
        end
        m_prev = p;
    endtask

    // Compare process: every cycle once reset has been seen, then advance the model.
    always @(negedge clk) begin
        int   n;
        logic e_valid, e_err, e_busy;
        n = cyc_n;
        if (model_ok && n < MAXC) begin
            e_valid = (m_valid_at == n);
            e_err   = (m_err_at == n);
            e_busy  = m_active && (n > m_t0) && !e_err;
            check("valid", {31'd0, bus.valid}, {31'd0, e_valid});
            check("frame_err", {31'd0, bus.frame_err}, {31'd0, e_err});
            check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
            check("value", bus.value, m_value);
            check("valid_and_err", {31'd0, bus.valid & bus.frame_err}, 32'd0);
            if (bus.valid === 1'b1) begin
                n_valid++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = n;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard at cycle %0d: got word %h, expected no word", n, bus.value);
                end else begin
                    check("scoreboard", bus.value, exp_q.pop_front());
                end
            end
            if (bus.frame_err === 1'b1) n_err++;
        end
        if (n < MAXC) model_step(n);
    end

    // Driver tasks
    task automatic drive(input logic r, input logic p, input logic [3:0] nb);
        @(posedge clk);
        #1;
        rst        = r;
        bus.pos_in = p;
        bus.nib_in = nb;
        if (cyc_n < MAXC) begin
            hist_rst[cyc_n] = r;
            hist_pos[cyc_n] = p;
            hist_nib[cyc_n] = nb;
        end
    endtask

    task automatic idle(input int c);
        repeat (c) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    // Drive ncyc cycles of a frame; pmask bit k is the strobe level in slot k;
    // glitch_slot flips nib[2] for one cycle at that slot's nominal sample point.
    task automatic send_frame(input logic [31:0] w, input logic [7:0] pmask,
                              input int glitch_slot, input int ncyc, output int s);
        s = -1;
        for (int i = 0; i < ncyc; i++) begin
            int         sl, j;
            logic [3:0] nb;
            sl = i / N;
            j  = i % N;
            nb = w[31-4*sl -: 4];
            if (sl == glitch_slot && j == N / 2) nb[2] = ~nb[2];
            drive(1'b0, pmask[sl], nb);
            if (i == 0) s = cyc_n;
        end
    endtask

    // Directed scenarios, then random frames, then the report
    initial begin
        int          s, s2, v0, e0;
        logic [31:0] w;
        logic [7:0]  pm;
        for (int i = 0; i < MAXC; i++) begin
            hist_pos[i] = 1'b0;
            hist_nib[i] = 4'd0;
            hist_rst[i] = (i == 0);
        end
        bus.pos_in = 1'b0;
        bus.nib_in = 4'd0;

        repeat (5) drive(1'b1, 1'b0, 4'd0);
        idle(5);
        @(negedge clk);
        check("reset_value", bus.value, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_state", {29'd0, state_dbg}, 32'd0);

        // Single clean frame
        v0 = n_valid; e0 = n_err;
        send_frame(32'hDEADBEEF, 8'h01, -1, 64, s);
        idle(10);
        @(negedge clk);
        check("deadbeef_value", bus.value, 32'hDEADBEEF);
        check("deadbeef_valid_cycle", last_valid_cyc, s + SS + 61 + MAJ);
        check("deadbeef_pulses", n_valid - v0, 32'd1);
        check("deadbeef_no_err", n_err - e0, 32'd0);

        // Back-to-back frames
        send_frame(32'h12345678, 8'h01, -1, 64, s);
        send_frame(32'h00000000, 8'h01, -1, 64, s2);
        idle(10);
        @(negedge clk);
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 32'd64);
        check("b2b_first_cycle", prev_valid_cyc, s + SS + 61 + MAJ);
        check("b2b_value", bus.value, 32'h00000000);

        // Strobe held through slots 0 and 1
        v0 = n_valid; e0 = n_err;
        send_frame($urandom, 8'h03, -1, 64, s);
        idle(10);
        @(negedge clk);
        check("pos01_err", n_err - e0, 32'd1);
        check("pos01_no_valid", n_valid - v0, 32'd0);
        check("pos01_value_kept", bus.value, 32'h00000000);

        // Re-sync: new strobe edge two cycles into slot 3
        idle(20);
        v0 = n_valid; e0 = n_err;
        send_frame($urandom, 8'h01, -1, 26, s);
        send_frame(32'hCAFEF00D, 8'h01, -1, 64, s2);
        idle(10);
        @(negedge clk);
        check("resync_err", n_err - e0, 32'd1);
        check("resync_valid", n_valid - v0, 32'd1);
        check("resync_value", bus.value, 32'hCAFEF00D);
        check("resync_valid_cycle", last_valid_cyc, s2 + SS + 61 + MAJ);

        // Reset during slot 5
        v0 = n_valid; e0 = n_err;
        send_frame($urandom, 8'h01, -1, 44, s);
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 4'd0);
        @(negedge clk);
        check("midrst_value", bus.value, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        idle(10);
        check("midrst_no_pulses", (n_valid - v0) + (n_err - e0), 32'd0);
        w = $urandom;
        send_frame(w, 8'h01, -1, 64, s);
        idle(10);
        @(negedge clk);
        check("after_rst_value", bus.value, w);

        // One-cycle glitch on nib[2] at the slot 5 sample point
        send_frame(32'hA5A5A5A5, 8'h01, 5, 64, s);
        idle(10);
        @(negedge clk);
        check("glitch_value", bus.value, (MAJ != 0) ? 32'hA5A5A5A5 : 32'hA5A5A1A5);

        // Random frames: random words, gaps, glitches and occasional stray strobe slots
        for (int f = 0; f < 12; f++) begin
            pm = 8'h01;
            if ($urandom_range(0, 3) == 0) pm[$urandom_range(1, 7)] = 1'b1;
            send_frame($urandom, pm, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, 64, s);
            idle($urandom_range(0, 20));
        end
        idle(90);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
